// File: rtl/prefix_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// master = issuing side, slave = adder side.
interface prefix_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, out_tag
    );

    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, cout, ovf, out_tag
    );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with elastic valid/ready ranks.
// Prefix levels are spread over STAGES register ranks; results carry a tag.
module prefix_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    prefix_adder_pipe_if.slave io
);
    localparam int L = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;

    function automatic int lev_end(input int s);
        if (s >= STAGES) return L;
        return (s * L + STAGES - 1) / STAGES;
    endfunction

    logic [STAGES:1] rv;
    logic [STAGES:1] rc0;
    logic [STAGES:1] ram;
    logic [STAGES:1] rbm;
    word_t           rg   [1:STAGES];
    word_t           rp   [1:STAGES];
    word_t           rpr  [1:STAGES];
    logic [TAGW-1:0] rtag [1:STAGES];

    logic [STAGES:1] iv;
    logic [STAGES:1] load;
    logic [STAGES:1] nc0;
    logic [STAGES:1] nam;
    logic [STAGES:1] nbm;
    word_t           ng   [1:STAGES];
    word_t           np   [1:STAGES];
    word_t           npr  [1:STAGES];
    logic [TAGW-1:0] ntag [1:STAGES];

    for (genvar s = 1; s <= STAGES; s++) begin : stage
        localparam int LB = lev_end(s - 1);
        localparam int LE = lev_end(s);

        word_t cg [LB:LE];
        word_t cp [LB:LE];

        if (s == 1) begin : first
            word_t bb;
            logic  c0;
            assign bb = io.sub ? ~io.b : io.b;
            assign c0 = io.sub | io.cin;
            assign cp[LB] = io.a ^ bb;
            // carry-in folded into bit 0 generate
            assign cg[LB] = (io.a & bb)
                          | {{(WIDTH-1){1'b0}}, cp[LB][0] & c0};
            assign npr[s]  = io.a ^ bb;
            assign nc0[s]  = c0;
            assign nam[s]  = io.a[WIDTH-1];
            assign nbm[s]  = bb[WIDTH-1];
            assign ntag[s] = io.in_tag;
            assign iv[s]   = io.in_valid;
        end else begin : mid
            assign cg[LB]  = rg[s-1];
            assign cp[LB]  = rp[s-1];
            assign npr[s]  = rpr[s-1];
            assign nc0[s]  = rc0[s-1];
            assign nam[s]  = ram[s-1];
            assign nbm[s]  = rbm[s-1];
            assign ntag[s] = rtag[s-1];
            assign iv[s]   = rv[s-1];
        end

        for (genvar k = LB; k < LE; k++) begin : level
            localparam int D = 1 << k;
            assign cg[k+1] = cg[k]
                | (cp[k] & {cg[k][WIDTH-1-D:0], {D{1'b0}}});
            assign cp[k+1] = cp[k]
                & {cp[k][WIDTH-1-D:0], {D{1'b1}}};
        end

        assign ng[s] = cg[LE];
        assign np[s] = cp[LE];
    end

    // a rank loads when empty or when its successor takes its contents
    always_comb begin
        logic chain;
        load  = '0;
        chain = io.out_ready;
        for (int s = STAGES; s >= 1; s--) begin
            load[s] = ~rv[s] | chain;
            chain   = load[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv  <= '0;
            rc0 <= '0;
            ram <= '0;
            rbm <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                rg[s]   <= '0;
                rp[s]   <= '0;
                rpr[s]  <= '0;
                rtag[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (load[s]) begin
                    rv[s] <= iv[s];
                    if (iv[s]) begin
                        rg[s]   <= ng[s];
                        rp[s]   <= np[s];
                        rpr[s]  <= npr[s];
                        rc0[s]  <= nc0[s];
                        ram[s]  <= nam[s];
                        rbm[s]  <= nbm[s];
                        rtag[s] <= ntag[s];
                    end
                end
            end
        end
    end

    word_t carry;
    word_t res;

    assign carry = {rg[STAGES][WIDTH-2:0], rc0[STAGES]};
    assign res   = rpr[STAGES] ^ carry;

    assign io.in_ready  = load[1];
    assign io.out_valid = rv[STAGES];
    assign io.sum       = res;
    assign io.cout      = rg[STAGES][WIDTH-1];
    assign io.ovf       = (ram[STAGES] == rbm[STAGES])
                        & (res[WIDTH-1] != ram[STAGES]);
    assign io.out_tag   = rtag[STAGES];
endmodule
